// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the unified memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - data-priority winner selection with fetch starvation guard
//
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   i_req, d_req      fetch / data requests
//   grant_en          arbiter is free to grant this cycle
//   grant_i, grant_d  one-hot winner, zero when grant_en is low
module mem_arb_prio #(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic d_req,
    input  logic grant_en,
    output logic grant_i,
    output logic grant_d
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    logic [3:0] streak_q, streak_d;
    logic       fetch_due;

    always_comb begin
        // Fetch has waited through the allowed number of data grants.
        fetch_due = i_req && (streak_q >= STREAK_MAX);
        grant_d   = grant_en && d_req && !fetch_due;
        grant_i   = grant_en && i_req && !grant_d;

        streak_d = streak_q;
        if (grant_i) begin
            streak_d = 4'd0;
        end else if (grant_d) begin
            if (!i_req) begin
                streak_d = 4'd0;
            end else if (streak_q < STREAK_MAX) begin
                streak_d = streak_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            streak_q <= 4'd0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-ported memory between fetch and data ports
//
// Ports:
//   clk, rst                       clock, synchronous active-low reset
//   i_req/i_addr/i_gnt/i_rvalid/i_rdata            fetch port
//   d_req/d_we/d_addr/d_wdata/d_be/d_gnt/d_rvalid/d_rdata  data port
//   stall_f, stall_m               pipeline holds until the access completes
//   mem_req_o..mem_be_o, mem_ready_i, mem_rvalid_i, mem_rdata_i  backing RAM
// Optional: define MEM_ARBITER_PERF_EN to add perf_i_stall, perf_d_stall,
//   perf_i_grants, perf_d_grants saturating 32-bit counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic [WIDTH-1:0] i_addr,
    output logic             i_gnt,
    output logic             i_rvalid,
    output logic [WIDTH-1:0] i_rdata,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    input  logic [3:0]       d_be,
    output logic             d_gnt,
    output logic             d_rvalid,
    output logic [WIDTH-1:0] d_rdata,
    output logic             stall_f,
    output logic             stall_m,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0] mem_wdata_o,
    output logic [3:0]       mem_be_o,
    input  logic             mem_ready_i,
    input  logic             mem_rvalid_i,
    input  logic [WIDTH-1:0] mem_rdata_i
`ifdef MEM_ARBITER_PERF_EN
    ,
    output logic [31:0]      perf_i_stall,
    output logic [31:0]      perf_d_stall,
    output logic [31:0]      perf_i_grants,
    output logic [31:0]      perf_d_grants
`endif
);

    arb_state_t       state_q, state_d;
    owner_t           owner_q, owner_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             we_q, we_d;
    logic [3:0]       be_q, be_d;

    logic grant_en, grant_i, grant_d;
    logic issuing;

    // Grants only from IDLE; reset forces every grant low.
    assign grant_en = rst && (state_q == IDLE);

    mem_arb_prio #(
        .MAX_DATA_STREAK(MAX_DATA_STREAK)
    ) u_prio (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .d_req    (d_req),
        .grant_en (grant_en),
        .grant_i  (grant_i),
        .grant_d  (grant_d)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        be_d     = be_q;
        i_rvalid = 1'b0;
        d_rvalid = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    owner_d = OWN_D;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    we_d    = d_we;
                    be_d    = d_be;
                    state_d = ISSUE;
                end else if (grant_i) begin
                    owner_d = OWN_I;
                    addr_d  = i_addr;
                    wdata_d = '0;
                    we_d    = 1'b0;
                    be_d    = BE_FULL;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ready_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Response is only meaningful here; stale pulses elsewhere are dropped.
                if (mem_rvalid_i && rst) begin
                    i_rvalid = (owner_q == OWN_I);
                    d_rvalid = (owner_q == OWN_D);
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= OWN_I;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            be_q    <= 4'h0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            be_q    <= be_d;
        end
    end

    assign issuing     = rst && (state_q == ISSUE);
    assign mem_req_o   = issuing;
    assign mem_we_o    = issuing && we_q;
    assign mem_addr_o  = issuing ? addr_q : '0;
    assign mem_wdata_o = issuing ? wdata_q : '0;
    assign mem_be_o    = issuing ? be_q : 4'h0;

    assign i_gnt   = grant_i;
    assign d_gnt   = grant_d;
    assign i_rdata = mem_rdata_i;
    assign d_rdata = mem_rdata_i;
    assign stall_f = rst && i_req && !i_rvalid;
    assign stall_m = rst && d_req && !d_rvalid;

`ifdef MEM_ARBITER_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_i_stall  <= '0;
            perf_d_stall  <= '0;
            perf_i_grants <= '0;
            perf_d_grants <= '0;
        end else begin
            if (stall_f && (perf_i_stall != '1)) perf_i_stall <= perf_i_stall + 32'd1;
            if (stall_m && (perf_d_stall != '1)) perf_d_stall <= perf_d_stall + 32'd1;
            if (grant_i && (perf_i_grants != '1)) perf_i_grants <= perf_i_grants + 32'd1;
            if (grant_d && (perf_d_grants != '1)) perf_d_grants <= perf_d_grants + 32'd1;
        end
    end
`endif

    // A granted requester must hold its request until its response arrives.
    a_i_req_held: assert property (@(posedge clk) disable iff (!rst)
        (state_q != IDLE && owner_q == OWN_I) |-> i_req);
    a_d_req_held: assert property (@(posedge clk) disable iff (!rst)
        (state_q != IDLE && owner_q == OWN_D) |-> d_req);

endmodule
